// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: default frame width and the FSM state encoding.
package spi_pkg;

    localparam int SPI_W_DATA = 32;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // The bit counter is one bit wider than the index so it can reach W_Data without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a configurable reset value.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, W_Data bits per frame, oversampling sclk/ss_n/mosi in the clk domain.
// o_dbg_state exposes the FSM state (ST_IDLE / ST_ACTIVE).
// Handshake: a tx word is accepted on a clk edge where tx_valid && tx_ready; tx_valid may be held
// until then. rx_valid is a one-cycle pulse with rx_data already updated; there is no backpressure.
module spi_slave
    import spi_pkg::*;
#(
    parameter int W_Data = SPI_W_DATA
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [W_Data-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [W_Data-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic [0:0]        o_dbg_state
);

    localparam int              CW       = cnt_width(W_Data);
    localparam logic [CW-1:0]   LAST_BIT = CW'(W_Data - 1);

    logic w_sclk_s;
    logic w_ss_s;
    logic w_mosi_s;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .i_d(sclk), .o_q(w_sclk_s));
    spi_sync #(.RST_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .i_d(ss_n), .o_q(w_ss_s));
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .i_d(mosi), .o_q(w_mosi_s));

    logic r_sclk_d;
    logic r_ss_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_d <= 1'b0;
            r_ss_d   <= 1'b1;
        end else begin
            r_sclk_d <= w_sclk_s;
            r_ss_d   <= w_ss_s;
        end
    end

    // ss_n held low across reset release must not look like a falling edge: the synchronizer
    // still shows its reset value for two cycles, so require three observed-high cycles first.
    logic [1:0] r_arm_cnt;
    logic       r_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arm_cnt <= 2'd0;
            r_armed   <= 1'b0;
        end else if (!r_armed) begin
            if (w_ss_s) begin
                r_arm_cnt <= r_arm_cnt + 2'd1;
                if (r_arm_cnt == 2'd2) begin
                    r_armed <= 1'b1;
                end
            end else begin
                r_arm_cnt <= 2'd0;
            end
        end
    end

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ss_fall;
    logic w_ss_rise;

    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ss_fall   = ~w_ss_s & r_ss_d & r_armed;
    assign w_ss_rise   = w_ss_s & ~r_ss_d;

    logic [0:0]        r_state;
    logic [CW-1:0]     r_bit_cnt;
    logic [W_Data-1:0] r_tx_sh;
    logic [W_Data-1:0] r_rx_sh;
    logic              r_miso;
    logic              r_underrun;
    logic              r_done;
    logic [W_Data-1:0] r_tx_buf;
    logic              r_buf_full;

    logic w_start;
    logic w_load;

    assign w_start = (r_state == ST_IDLE) & w_ss_fall;
    assign w_load  = tx_valid & ~r_buf_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_bit_cnt  <= '0;
            r_tx_sh    <= '0;
            r_rx_sh    <= '0;
            r_miso     <= 1'b0;
            r_underrun <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_state    <= ST_ACTIVE;
                        r_bit_cnt  <= '0;
                        r_tx_sh    <= r_buf_full ? r_tx_buf : '0;
                        r_miso     <= r_buf_full & r_tx_buf[W_Data-1];
                        r_underrun <= ~r_buf_full;
                    end else if (w_ss_rise) begin
                        r_miso <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (w_ss_rise) begin
                        r_state   <= ST_IDLE;
                        r_bit_cnt <= '0;
                        r_miso    <= 1'b0;
                    end else if (w_sclk_rise) begin
                        r_rx_sh   <= {r_rx_sh[W_Data-2:0], w_mosi_s};
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state <= ST_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        r_tx_sh <= r_tx_sh << 1;
                        r_miso  <= r_tx_sh[W_Data-2];
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // A load landing on the frame-start cycle goes into the buffer for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_full <= 1'b0;
            r_tx_buf   <= '0;
        end else if (w_start) begin
            r_buf_full <= w_load;
            if (w_load) begin
                r_tx_buf <= tx_data;
            end
        end else if (w_load) begin
            r_buf_full <= 1'b1;
            r_tx_buf   <= tx_data;
        end
    end

    logic [W_Data-1:0] r_rx_data;
    logic              r_rx_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= r_done;
            if (r_done) begin
                r_rx_data <= r_rx_sh;
            end
        end
    end

    assign tx_ready    = ~r_buf_full;
    assign miso_oe     = ~w_ss_s;
    assign miso        = r_miso & ~w_ss_s;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_underrun;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: an SPI initiator model, a tx-buffer model and an rx scoreboard queue.
module tb_spi_slave;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         sclk;
  logic         ss_n;
  logic         mosi;
  logic         miso;
  logic         miso_oe;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         tx_underrun;
  logic [0:0]   dbg_state;

  spi_slave #(.W_Data(W)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  int n_rxv = 0;
  int n_ur = 0;
  int exp_rxv = 0;
  int exp_ur = 0;

  // Model: one-word transmit buffer, last word the slave should report
  logic         m_full = 1'b0;
  logic [W-1:0] m_buf = '0;
  logic [W-1:0] m_last_rx = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitor: every rx_valid pulse pops one expected word
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    if (tx_underrun) n_ur++;
    if (rx_valid) begin
      n_rxv++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_spurious actual=%h expected=no_pulse", rx_data);
      end else begin
        exp_w = exp_q.pop_front();
        check("rx_data", rx_data, exp_w);
      end
    end
  end

  task automatic load_tx(input logic [W-1:0] d);
    int t = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL load_timeout actual=tx_ready_low expected=accept");
      tx_valid = 1'b0;
    end else begin
      @(negedge clk);
      tx_valid = 1'b0;
      m_full   = 1'b1;
      m_buf    = d;
    end
  endtask

  // Initiator: mode 0, MSB first, nbits bits, half-period h clk cycles.
  task automatic run_frame(input logic [W-1:0] word, input int nbits, input int h, input bit end_ss);
    logic [W-1:0] exp_miso;
    logic [W-1:0] got;
    exp_miso = m_full ? m_buf : '0;
    if (!m_full) exp_ur++;
    m_full = 1'b0;
    if (nbits == W) begin
      exp_q.push_back(word);
      exp_rxv++;
      m_last_rx = word;
    end
    got  = '0;
    ss_n = 1'b0;
    mosi = word[W-1];
    repeat (h) @(negedge clk);
    check("miso_oe_sel", {31'd0, miso_oe}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      got  = {got[W-2:0], miso};
      sclk = 1'b1;
      repeat (h) @(negedge clk);
      sclk = 1'b0;
      if (i < W - 1) mosi = word[W-2-i];
      repeat (h) @(negedge clk);
    end
    check("miso_word", got, exp_miso >> (W - nbits));
    if (end_ss) begin
      ss_n = 1'b1;
      repeat (h) @(negedge clk);
    end
  endtask

  task automatic post_check();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    check("rx_drain", exp_q.size(), 0);
    check("rx_valid_count", n_rxv, exp_rxv);
    check("underrun_count", n_ur, exp_ur);
    check("rx_data_hold", rx_data, m_last_rx);
    check("tx_ready", {31'd0, tx_ready}, {31'd0, !m_full});
    check("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
    check("miso_idle", {31'd0, miso}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_rx_data", rx_data, 32'd0);
    check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_tx_underrun", {31'd0, tx_underrun}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // known-word exchange
    load_tx(32'hA5A5_0F0F);
    check("tx_ready_full", {31'd0, tx_ready}, 32'd0);
    run_frame(32'h1234_5678, W, 4, 1'b1);
    post_check();

    // empty buffer: zeros out, underrun pulse, rx still delivered
    run_frame($urandom, W, 5, 1'b1);
    post_check();

    // abort after 17 bits, then a clean frame
    load_tx($urandom);
    run_frame($urandom, 17, 4, 1'b1);
    post_check();
    load_tx($urandom);
    run_frame(32'hDEAD_BEEF, W, 4, 1'b1);
    post_check();

    // load offered as ss_n falls while the buffer is still full
    load_tx(32'h1111_1111);
    fork
      run_frame($urandom, W, 4, 1'b1);
      load_tx(32'h2222_2222);
    join
    post_check();
    run_frame($urandom, W, 4, 1'b1);
    post_check();

    // empty buffer, load landing on the frame-start cycle is held for the next frame
    fork
      run_frame($urandom, W, 4, 1'b1);
      begin
        repeat (2) @(negedge clk);
        load_tx(32'h3333_3333);
      end
    join
    post_check();
    run_frame($urandom, W, 4, 1'b1);
    post_check();

    // extra sclk edges after a completed frame with ss_n still low are ignored
    load_tx($urandom);
    run_frame($urandom, W, 4, 1'b0);
    for (int i = 0; i < 6; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    ss_n = 1'b1;
    repeat (4) @(negedge clk);
    post_check();

    // back-to-back frames at the minimum sclk period
    load_tx($urandom);
    run_frame($urandom, W, 4, 1'b1);
    run_frame($urandom, W, 4, 1'b1);
    post_check();

    // randomized frames
    for (int n = 0; n < 6; n++) begin
      int h;
      h = $urandom_range(4, 8);
      if ($urandom_range(0, 1) == 1) load_tx($urandom);
      run_frame($urandom, W, h, 1'b1);
      post_check();
    end

    // reset at bit 10, ss_n held low through release
    load_tx($urandom);
    run_frame($urandom, 10, 4, 1'b0);
    rst = 1'b1;
    m_full = 1'b0;
    m_last_rx = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_miso", {31'd0, miso}, 32'd0);
    check("post_rst_miso_oe", {31'd0, miso_oe}, 32'd1);
    for (int i = 0; i < W; i++) begin
      mosi = 1'($urandom_range(0, 1));
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("post_rst_no_rx", n_rxv, exp_rxv);
    check("post_rst_no_underrun", n_ur, exp_ur);
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
    post_check();
    run_frame($urandom, W, 4, 1'b1);
    post_check();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
